rr_sel_arbiter: RTL
===================

# rr_sel_arbiter

Round-robin arbiter that generates the select for the N-to-1 data mux. Up to NUM_REQ sources raise request lines; the block picks one fairly, presents its index on `sel` plus a one-hot `grant`, and holds both under a valid/ready handshake until the downstream consumer accepts. `sel` wires directly to the mux select port. The mux output is qualified by `out_valid`/`out_ready`.

## Interface
- NUM_REQ, default 8: number of requesters. Legal range is 2..2**SEL_W.
- SEL_W, default 3: select width, matching the mux `width_sel`.
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous active-low reset, released synchronously by the integrator.
- req  in  NUM_REQ: request per source. The source holds the bit high until its transfer completes.
- out_ready  in  1: the downstream consumer accepts the current selection.
- out_valid  out  1: `sel`/`grant` hold a live selection.
- sel  out  SEL_W: index of the granted source; drives the mux select.
- grant  out  NUM_REQ: one-hot form of `sel`; all-zero when `out_valid`=0.
- xfer  out  1: combinational `out_valid & out_ready`; the transfer strobe for sources.

## Operation
- Internal state:
  - FSM with two states, IDLE and HOLD.
  - Priority pointer `ptr`, SEL_W bits.
- Arbitration function:
  - Candidate mask is `req`, except on a transfer edge, where it is `req & ~grant`. The consumed bit is masked so a source is never re-granted on the edge its item leaves.
  - Search the mask starting at index `ptr`, ascending. Wrap from NUM_REQ-1 to 0.
  - The first set bit wins.
- IDLE (out_valid=0, grant=0):
  - If any `req` bit is set, load the winner into `sel`/`grant`, set out_valid=1, go to HOLD.
  - Otherwise stay in IDLE.
- HOLD (out_valid=1):
  - out_ready=0: `sel`, `grant` and `ptr` are frozen, regardless of `req` changes. This includes the granted source dropping its `req`; a grant is never withdrawn.
  - out_ready=1 (transfer):
    - `ptr` <= granted index + 1, wrapping to 0 when the granted index is NUM_REQ-1.
    - If the masked candidate set is non-empty, grant the new winner in the same edge and stay in HOLD. The new search uses the updated `ptr`.
    - Otherwise clear `grant`, out_valid=0, go to IDLE. `sel` keeps its last value.
- A single persistent requester is granted every other cycle (50% throughput); this is intentional.
- Two or more persistent requesters give back-to-back grants at 100% throughput, rotating in index order.
- Bits of `req` at or above NUM_REQ do not exist. `sel` never exceeds NUM_REQ-1.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - out_valid=0, sel=0, grant=0, ptr=0, state=IDLE.
  - xfer=0, since out_valid=0.
- Latency:
  - `req` rising in cycle N gives out_valid=1 after the edge ending cycle N, so it is visible in cycle N+1.
  - No combinational path from `req` to any output.
- Transfer: occurs on the edge where out_valid=1 and out_ready=1. The next selection, if any, is visible in the following cycle with no bubble.
- `out_ready` is sampled only in HOLD. `out_ready` high while IDLE has no effect.
- Reset asserted mid-HOLD: the selection is dropped immediately and no transfer is counted. After release, arbitration restarts from `ptr`=0.
- `grant` is always one-hot or zero, and always equals decode(`sel`) while out_valid=1.

## Test plan
- Reset and single request:
  - Assert rst_n=0 with req=8'hFF: all outputs are 0.
  - Release, then req=8'h10: out_valid=1 and sel=4 one cycle later.
  - Hold out_ready=1: source 4 is granted every other cycle.
- Full rotation: req=8'hFF, out_ready=1 continuously -> sel sequence 0,1,2,...,7,0 on consecutive cycles, out_valid never drops.
- Backpressure:
  - With sel=3 granted, hold out_ready=0 for 5 cycles while toggling req[3] and req[5]: sel=3 and grant=8'h08 stay stable.
  - Raise out_ready: the next sel is 5.
- Wrap-around and skip: ptr=6 (after a grant to 5), req=8'b0000_0101 -> sel=0, then sel=2; ptr ends at 3.
- Non-power-of-two: NUM_REQ=5, SEL_W=3, req=5'b1_0001, out_ready=1 -> sel alternates 0,4,0,4; sel never reaches 5..7.
- Reset mid-operation:
  - Pulse rst_n low asynchronously between edges while in HOLD with sel=6: out_valid falls without waiting for an edge.
  - After release with req=8'hC0: sel=6 (search from 0).

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter producing the select for an N-to-1 mux.
// The chosen source index is presented on sel (plus one-hot grant) and held
// under a valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-source request, held high until its transfer completes
//   out_ready  consumer accepts the current selection
//   out_valid  sel/grant hold a live selection
//   sel        granted index, drives the mux select
//   grant      one-hot of sel, zero when out_valid=0
//   xfer       out_valid & out_ready, transfer strobe back to the sources
module rr_sel_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               xfer
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_nxt;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   win;
  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [SEL_W:0]     idx;

  // out_valid is only ever high in HOLD, so this is the HOLD transfer edge.
  assign xfer = out_valid & out_ready;

  // Pointer moves one past the source being consumed, wrapping at NUM_REQ.
  assign ptr_nxt = (sel == SEL_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;

  // Circular first-set search from start. On a transfer edge the outgoing
  // source is masked and the search already uses the advanced pointer, so a
  // follow-on grant lands in the same edge without a bubble.
  always_comb begin
    cand  = xfer ? (req & ~grant) : req;
    start = xfer ? ptr_nxt : ptr;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, start} + (SEL_W+1)'(i);
      if (idx >= (SEL_W+1)'(NUM_REQ)) idx = idx - (SEL_W+1)'(NUM_REQ);
      if (!found && cand[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sel       <= '0;
      grant     <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= win;
            grant     <= NUM_REQ'(1) << win;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Without out_ready everything is frozen: a grant is never withdrawn.
          if (out_ready) begin
            ptr <= ptr_nxt;
            if (found) begin
              sel   <= win;
              grant <= NUM_REQ'(1) << win;
            end else begin
              // sel keeps its last value; only grant/valid drop.
              grant     <= '0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
